// File: rtl/noc_flit_injector_pkg.sv
// Shared definitions for the NoC flit injector: FSM encoding, flit field positions, log2 helper.
package noc_flit_injector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } inj_state_e;

    // Ceiling log2 with a floor of 1 so a single-VC index still has one bit.
    function automatic int log2c(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    function automatic int hdr_bit(input int fw);
        return fw - 1;
    endfunction

    function automatic int tail_bit(input int fw);
        return fw - 2;
    endfunction

    function automatic int vc_msb(input int fw);
        return fw - 3;
    endfunction

endpackage

// File: rtl/noc_flit_injector_credit.sv
// Per-VC credit counter: starts full at B, saturates at 0 and B.
module inj_credit_counter
    import noc_flit_injector_pkg::*;
#(
    parameter int B = 4
)(
    input  logic clk,
    input  logic reset,
    input  logic i_take,
    input  logic i_give,
    output logic o_nonzero
);
    localparam int CW = log2c(B + 1);

    logic [CW-1:0] r_count;

    // A take and a give in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= CW'(B);
        end else if (i_take && !i_give && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end else if (i_give && !i_take && (r_count != CW'(B))) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_nonzero = (r_count != '0);

endmodule

// File: rtl/noc_flit_injector.sv
// Packet-to-flit injector: turns a packet command plus body words into credit-gated flits.
//   state | meaning
//   IDLE  | accepting a packet command
//   HEAD  | waiting for a credit to send the header flit
//   BODY  | sending body flits, one per accepted data word
module noc_flit_injector
    import noc_flit_injector_pkg::*;
#(
    parameter int V    = 2,
    parameter int B    = 4,
    parameter int Fpay = 32,
    parameter int EAw  = 2,
    parameter int LENw = 4,
    localparam int Fw  = 2 + V + Fpay,
    localparam int VCW = log2c(V)
)(
    input  logic            clk,
    input  logic            reset,
    input  logic [EAw-1:0]  current_e_addr,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [EAw-1:0]  req_dest,
    input  logic [LENw-1:0] req_len,
    input  logic [VCW-1:0]  req_vc,
    input  logic            data_valid,
    output logic            data_ready,
    input  logic [Fpay-1:0] data_in,
    output logic [Fw-1:0]   flit_out,
    output logic            flit_out_wr,
    input  logic [V-1:0]    credit_in,
    output logic [15:0]     pck_sent
);
    localparam int HDR_B  = hdr_bit(Fw);
    localparam int TAIL_B = tail_bit(Fw);
    localparam int VC_MSB = vc_msb(Fw);

    inj_state_e      r_state, w_state_nxt;
    logic [EAw-1:0]  r_dest;
    logic [LENw-1:0] r_len;
    logic [LENw-1:0] r_remaining;
    logic [VCW-1:0]  r_vc;
    logic [Fw-1:0]   r_flit;
    logic            r_flit_wr;
    logic [15:0]     r_pck_sent;

    logic [V-1:0]    w_cred_nz;
    logic [V-1:0]    w_take;
    logic [V-1:0]    w_vc_oh;
    logic            w_vc_ok;
    logic            w_issue;
    logic            w_tail;
    logic            w_hdr;
    logic [Fpay-1:0] w_pay;
    logic [Fw-1:0]   w_flit;

    for (genvar gi = 0; gi < V; gi++) begin : g_cred
        assign w_take[gi] = w_issue && (r_vc == VCW'(gi));
        inj_credit_counter #(.B(B)) u_cred (
            .clk       (clk),
            .reset     (reset),
            .i_take    (w_take[gi]),
            .i_give    (credit_in[gi]),
            .o_nonzero (w_cred_nz[gi])
        );
    end

    // Registered count only: a credit returning this cycle enables issue next cycle.
    assign w_vc_ok = w_cred_nz[r_vc];

    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_state_nxt = ST_HEAD;
            ST_HEAD: if (w_issue)   w_state_nxt = w_tail ? ST_IDLE : ST_BODY;
            ST_BODY: if (w_issue && w_tail) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        data_ready = 1'b0;
        w_issue    = 1'b0;
        w_hdr      = 1'b0;
        w_tail     = 1'b0;
        case (r_state)
            ST_IDLE: req_ready = 1'b1;
            ST_HEAD: begin
                w_hdr   = 1'b1;
                w_issue = w_vc_ok;
                w_tail  = (r_len == LENw'(1));
            end
            ST_BODY: begin
                data_ready = w_vc_ok;
                w_issue    = w_vc_ok && data_valid;
                w_tail     = (r_remaining == LENw'(1));
            end
            default: ;
        endcase
    end

    always_comb begin
        w_pay   = data_in;
        w_vc_oh = '0;
        w_vc_oh[r_vc] = 1'b1;
        if (w_hdr) begin
            w_pay = '0;
            w_pay[EAw-1:0]     = r_dest;
            w_pay[2*EAw-1:EAw] = current_e_addr;
        end
        w_flit = '0;
        w_flit[HDR_B]         = w_hdr;
        w_flit[TAIL_B]        = w_tail;
        w_flit[VC_MSB:Fpay]   = w_vc_oh;
        w_flit[Fpay-1:0]      = w_pay;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dest      <= '0;
            r_len       <= '0;
            r_vc        <= '0;
            r_remaining <= '0;
            r_flit      <= '0;
            r_flit_wr   <= 1'b0;
            r_pck_sent  <= '0;
        end else begin
            r_flit_wr <= w_issue;
            if (w_issue) r_flit <= w_flit;
            if (w_issue && w_tail) r_pck_sent <= r_pck_sent + 16'd1;
            if ((r_state == ST_IDLE) && req_valid) begin
                r_dest <= req_dest;
                r_vc   <= req_vc;
                r_len  <= (req_len == '0) ? LENw'(1) : req_len;
            end
            if (w_issue) begin
                r_remaining <= (r_state == ST_HEAD) ? (r_len - LENw'(1))
                                                    : (r_remaining - LENw'(1));
            end
        end
    end

    assign flit_out    = r_flit;
    assign flit_out_wr = r_flit_wr;
    assign pck_sent    = r_pck_sent;

endmodule

// File: tb/tb_noc_flit_injector.sv
// Scoreboard bench for noc_flit_injector: requests push expected flits, a monitor pops on flit_out_wr.
module tb_noc_flit_injector;
    localparam int V = 2;
    localparam int B = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  current_e_addr = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_dest = '0;
    logic [3:0]  req_len = '0;
    logic [0:0]  req_vc = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [31:0] data_in = '0;
    logic [35:0] flit_out;
    logic        flit_out_wr;
    logic [1:0]  credit_in;
    logic [15:0] pck_sent;

    logic [1:0]  cr_auto = '0;
    logic [1:0]  cr_man = '0;
    assign credit_in = cr_auto | cr_man;

    noc_flit_injector #(.V(V), .B(B), .Fpay(32), .EAw(2), .LENw(4)) dut (
        .clk(clk), .reset(reset), .current_e_addr(current_e_addr),
        .req_valid(req_valid), .req_ready(req_ready), .req_dest(req_dest),
        .req_len(req_len), .req_vc(req_vc), .data_valid(data_valid),
        .data_ready(data_ready), .data_in(data_in), .flit_out(flit_out),
        .flit_out_wr(flit_out_wr), .credit_in(credit_in), .pck_sent(pck_sent)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [35:0] exp_q[$];
    logic [31:0] dq[$];
    int          pend[2] = '{0, 0};
    int          flits_rx = 0;
    logic [35:0] last_flit = '0;
    logic [15:0] exp_pck = '0;
    bit          auto_credit = 1'b1;
    bit          data_always = 1'b0;
    bit          fire = 1'b0;

    function automatic logic [35:0] mk_flit(input bit hdr, input bit tail, input int vc,
                                           input logic [31:0] pay);
        logic [1:0] oh;
        oh = (vc == 1) ? 2'b10 : 2'b01;
        return {hdr, tail, oh, pay};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic [35:0] got, exp;
        int vci;
        forever begin
            @(negedge clk);
            if (reset && flit_out_wr) begin
                got = flit_out;
                flits_rx++;
                last_flit = got;
                vci = (got[33:32] == 2'b10) ? 1 : 0;
                pend[vci]++;
                checks++;
                if (pend[vci] > B) begin
                    errors++;
                    $display("FAIL credit_overrun vc=%0d outstanding=%0d limit=%0d", vci, pend[vci], B);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_flit actual=%h required=none", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL flit actual=%h required=%h", got, exp);
                    end
                end
                if (got[34]) begin
                    exp_pck++;
                    chk("pck_sent_on_tail", 64'(pck_sent), 64'(exp_pck));
                end
            end else if (reset) begin
                chk("flit_hold", 64'(flit_out), 64'(last_flit));
            end
        end
    end

    // Router model: returns one credit per received flit, with random delay
    initial begin
        forever begin
            @(negedge clk);
            for (int v = 0; v < V; v++) begin
                cr_auto[v] = 1'b0;
                if (auto_credit && pend[v] > 0 && $urandom_range(0, 1) == 1) begin
                    cr_auto[v] = 1'b1;
                    pend[v]--;
                end
            end
        end
    end

    // Body-word source
    initial begin
        forever begin
            @(negedge clk);
            if (fire && dq.size() > 0) void'(dq.pop_front());
            if (dq.size() > 0 && (data_always || $urandom_range(0, 3) != 0)) begin
                data_valid = 1'b1;
                data_in    = dq[0];
            end else begin
                data_valid = 1'b0;
                data_in    = $urandom;
            end
            #1 fire = data_valid && data_ready;
        end
    end

    task automatic send_pkt(input logic [1:0] dest, input logic [3:0] len, input int vc,
                            input logic [1:0] src, input bit seq, input logic [31:0] base);
        int n;
        int waited;
        logic [31:0] w;
        waited = 0;
        do begin
            @(negedge clk); #2;
            waited++;
        end while (!req_ready && waited < 2000);
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout actual=0 required=1");
            return;
        end
        n = (len == 0) ? 1 : int'(len);
        exp_q.push_back(mk_flit(1'b1, n == 1, vc, {28'b0, src, dest}));
        for (int i = 1; i < n; i++) begin
            w = seq ? (base + 32'(i - 1)) : $urandom;
            dq.push_back(w);
            exp_q.push_back(mk_flit(1'b0, i == n - 1, vc, w));
        end
        current_e_addr = src;
        req_dest  = dest;
        req_len   = len;
        req_vc    = 1'(vc);
        req_valid = 1'b1;
        @(negedge clk); #2;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || (auto_credit && (pend[0] != 0 || pend[1] != 0))) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_drain_timeout actual=%0d_pending required=0", tag, exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    initial begin
        int n0;
        int k;
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int k;
        // Reset state
        reset = 1'b0;
        wait_cycles(3);
        chk("rst_flit_out_wr", 64'(flit_out_wr), 64'd0);
        chk("rst_flit_out", 64'(flit_out), 64'd0);
        chk("rst_pck_sent", 64'(pck_sent), 64'd0);
        chk("rst_data_ready", 64'(data_ready), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        reset = 1'b1;

        // Single-flit packet: header+tail, VC0 one-hot = 01, dest=3, src=0
        send_pkt(2'd3, 4'd1, 0, 2'd0, 1'b0, 32'd0);
        wait_idle(200, "len1");
        chk("len1_flit", 64'(last_flit), 64'h0_D_0000_0003);
        chk("len1_pck_sent", 64'(pck_sent), 64'd1);

        // Four-flit packet on VC1 with body 0xA,0xB,0xC
        send_pkt(2'd2, 4'd4, 1, 2'd1, 1'b1, 32'hA);
        wait_idle(200, "len4");
        chk("len4_last_flit", 64'(last_flit), 64'h0_6_0000_000C);
        chk("len4_pck_sent", 64'(pck_sent), 64'd2);

        // Zero length is sent as a single header+tail flit
        n0 = flits_rx;
        send_pkt(2'd1, 4'd0, 1, 2'd2, 1'b0, 32'd0);
        wait_idle(200, "len0");
        chk("len0_flit_count", 64'(flits_rx - n0), 64'd1);
        chk("len0_flit", 64'(last_flit), 64'h0_E_0000_0009);

        // Credit exhaustion: only B flits without returns, then one per returned credit
        auto_credit = 1'b0;
        data_always = 1'b1;
        n0 = flits_rx;
        send_pkt(2'd0, 4'd6, 0, 2'd3, 1'b0, 32'd0);
        wait_cycles(20);
        chk("stall_flit_count", 64'(flits_rx - n0), 64'd4);
        chk("stall_data_ready", 64'(data_ready), 64'd0);
        cr_man[0] = 1'b1;
        pend[0]--;
        wait_cycles(1);
        cr_man[0] = 1'b0;
        chk("credit_no_same_cycle_issue", 64'(flit_out_wr), 64'd0);
        chk("credit_data_ready", 64'(data_ready), 64'd1);
        wait_cycles(1);
        chk("credit_next_cycle_issue", 64'(flit_out_wr), 64'd1);
        wait_cycles(5);
        chk("credit_one_more_flit", 64'(flits_rx - n0), 64'd5);
        auto_credit = 1'b1;
        wait_idle(300, "stall");

        // Credit returned in the same cycle as an issue leaves the counter unchanged
        auto_credit = 1'b0;
        n0 = flits_rx;
        send_pkt(2'd1, 4'd6, 1, 2'd0, 1'b0, 32'd0);
        k = 0;
        while (k < 50) begin
            @(negedge clk); #2;
            if (data_valid && data_ready && pend[1] > 0) break;
            k++;
        end
        chk("same_cycle_found", 64'(k < 50), 64'd1);
        cr_man[1] = 1'b1;
        pend[1]--;
        wait_cycles(1);
        cr_man[1] = 1'b0;
        wait_cycles(20);
        chk("same_cycle_flit_count", 64'(flits_rx - n0), 64'd5);
        chk("same_cycle_data_ready", 64'(data_ready), 64'd0);
        auto_credit = 1'b1;
        wait_idle(300, "same_cycle");

        // Reset mid-packet abandons it; a following packet goes out cleanly
        n0 = flits_rx;
        send_pkt(2'd2, 4'd5, 0, 2'd1, 1'b0, 32'd0);
        k = 0;
        while ((flits_rx - n0) < 2 && k < 100) begin
            @(negedge clk); #2;
            k++;
        end
        chk("midpkt_two_flits", 64'(flits_rx - n0 >= 2), 64'd1);
        reset = 1'b0;
        wait_cycles(1);
        exp_q.delete();
        dq.delete();
        pend[0] = 0;
        pend[1] = 0;
        last_flit = '0;
        exp_pck = '0;
        wait_cycles(1);
        reset = 1'b1;
        wait_cycles(1);
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);
        chk("post_rst_flit_out_wr", 64'(flit_out_wr), 64'd0);
        chk("post_rst_flit_out", 64'(flit_out), 64'd0);
        chk("post_rst_pck_sent", 64'(pck_sent), 64'd0);
        n0 = flits_rx;
        auto_credit = 1'b0;
        send_pkt(2'd3, 4'd2, 1, 2'd2, 1'b1, 32'h55);
        wait_cycles(10);
        chk("post_rst_len2_count", 64'(flits_rx - n0), 64'd2);
        chk("post_rst_len2_pck", 64'(pck_sent), 64'd1);
        auto_credit = 1'b1;
        wait_idle(200, "post_rst");

        // Randomized traffic
        data_always = 1'b0;
        for (int p = 0; p < 25; p++) begin
            send_pkt(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                     int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, 32'd0);
        end
        wait_idle(5000, "random");
        chk("final_pck_sent", 64'(pck_sent), 64'(exp_pck));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
